// File: rtl/pwm_spd_decoder_if.sv
// Bundle of the complementary PWM leg pair and the decoded speed report.
// spd_vld is a one-cycle strobe with no back-pressure: spd is valid in any cycle
// where spd_vld is high, and it holds its value until the next strobe.
interface pwm_spd_decoder_if;
  logic        PWM_sig;
  logic        PWM_sig_n;
  logic [10:0] spd;
  logic        spd_vld;
  logic        per_err;
  logic        stuck;
  logic        ovlp;

  modport master (
    output PWM_sig, PWM_sig_n,
    input  spd, spd_vld, per_err, stuck, ovlp
  );

  modport slave (
    input  PWM_sig, PWM_sig_n,
    output spd, spd_vld, per_err, stuck, ovlp
  );
endinterface

// File: rtl/pwm_spd_decoder.sv
// Recovers the signed speed from a complementary PWM pair by timing the high
// phase of each period; also reports period errors, stuck legs and shoot-through.
module pwm_spd_decoder #(
  parameter int PERIOD  = 2048,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  pwm_spd_decoder_if.slave   bus,
  output logic               state_o
);
  typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} state_t;

  localparam logic [11:0] TO_LAST  = 12'(TIMEOUT - 1);
  localparam logic [12:0] PER_LEN  = 13'(PERIOD);

  state_t      state_q, state_d;
  logic        s_q, s_n_q, s_d_q;
  logic [11:0] per_cnt_q, per_cnt_d;
  logic [11:0] hi_cnt_q, hi_cnt_d;
  logic [10:0] spd_q, spd_d;
  logic        spd_vld_q, spd_vld_d;
  logic        per_err_q, per_err_d;
  logic        stuck_q, stuck_d;
  logic        ovlp_q, ovlp_d;

  logic        rise;
  logic        timeout;
  logic        per_ok;

  assign rise    = s_q & ~s_d_q;
  // A rise in the timeout cycle takes precedence over the stuck report.
  assign timeout = (per_cnt_q == TO_LAST) && !rise;
  assign per_ok  = ({1'b0, per_cnt_q} + 13'd1) == PER_LEN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= 1'b0;
      s_n_q     <= 1'b0;
      s_d_q     <= 1'b0;
      per_cnt_q <= 12'd0;
      hi_cnt_q  <= 12'd0;
      spd_q     <= 11'h000;
      spd_vld_q <= 1'b0;
      per_err_q <= 1'b0;
      stuck_q   <= 1'b0;
      ovlp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= bus.PWM_sig;
      s_n_q     <= bus.PWM_sig_n;
      s_d_q     <= s_q;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      spd_q     <= spd_d;
      spd_vld_q <= spd_vld_d;
      per_err_q <= per_err_d;
      stuck_q   <= stuck_d;
      ovlp_q    <= ovlp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rise) begin
      state_d = MEAS;
    end else if (timeout) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    spd_d     = spd_q;
    spd_vld_d = 1'b0;
    per_err_d = 1'b0;
    stuck_d   = stuck_q;
    ovlp_d    = ovlp_q | (s_q & s_n_q);

    if (rise || timeout) begin
      per_cnt_d = 12'd0;
    end else if (per_cnt_q != 12'hFFF) begin
      per_cnt_d = per_cnt_q + 12'd1;
    end

    // The rise cycle itself is high, so the new high count starts at 1.
    if (rise) begin
      hi_cnt_d = 12'd1;
    end else if (s_q && hi_cnt_q != 12'hFFF) begin
      hi_cnt_d = hi_cnt_q + 12'd1;
    end

    if (rise && state_q == MEAS) begin
      if (per_ok) begin
        spd_d     = hi_cnt_q[10:0] - 11'h400;
        spd_vld_d = 1'b1;
        stuck_d   = 1'b0;
      end else begin
        per_err_d = 1'b1;
      end
    end else if (timeout) begin
      spd_d     = s_q ? 11'h3FF : 11'h400;
      spd_vld_d = 1'b1;
      stuck_d   = 1'b1;
    end
  end

  assign bus.spd     = spd_q;
  assign bus.spd_vld = spd_vld_q;
  assign bus.per_err = per_err_q;
  assign bus.stuck   = stuck_q;
  assign bus.ovlp    = ovlp_q;
  assign state_o     = (state_q == MEAS);
endmodule
